// File: rtl/arith_div_if.sv
// Handshake and result bundle for the iterative divider.
interface arith_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALUop;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Quot;
   logic [WIDTH-1:0] Rem;
   logic             C;
   logic             V;

   modport master (
      output start, A, B, ALUop,
      input  busy, done, Quot, Rem, C, V
   );

   modport slave (
      input  start, A, B, ALUop,
      output busy, done, Quot, Rem, C, V
   );
endinterface

// File: rtl/arith_div.sv
// Restoring shift/subtract divider, one quotient bit per cycle.
// ARITH_DIV_EARLY_EN: skip the loop when |A| < |B|.
module arith_div #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst_n,
   arith_div_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] a_raw;
   logic             neg_q;
   logic             neg_r;
   logic             div0;
   logic             ovf;

   logic             sgn;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic             early;
   logic [WIDTH:0]   shl;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             unused_op;

   assign sgn   = bus.ALUop[0];
   assign a_neg = sgn & bus.A[WIDTH-1];
   assign b_neg = sgn & bus.B[WIDTH-1];
   assign a_abs = a_neg ? -bus.A : bus.A;
   assign b_abs = b_neg ? -bus.B : bus.B;
   assign unused_op = ^bus.ALUop[3:1];

`ifdef ARITH_DIV_EARLY_EN
   assign early = a_abs < b_abs;
`else
   assign early = 1'b0;
`endif

   // rem < dsr always holds, so WIDTH+1 bits keep the trial sign exact
   assign shl   = {rem, dvd[WIDTH-1]};
   assign trial = shl - {1'b0, dsr};
   assign q_fix = neg_q ? -dvd : dvd;
   assign r_fix = neg_r ? -rem : rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         dvd      <= '0;
         rem      <= '0;
         dsr      <= '0;
         a_raw    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div0     <= 1'b0;
         ovf      <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.Quot <= '0;
         bus.Rem  <= '0;
         bus.C    <= 1'b0;
         bus.V    <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  a_raw    <= bus.A;
                  dsr      <= b_abs;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  div0     <= (bus.B == '0);
                  ovf      <= sgn
                            && bus.A == {1'b1, {(WIDTH-1){1'b0}}}
                            && bus.B == '1;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  if (bus.B == '0) begin
                     dvd   <= a_abs;
                     rem   <= '0;
                     state <= FIX;
                  end else if (early) begin
                     dvd   <= '0;
                     rem   <= a_abs;
                     state <= FIX;
                  end else begin
                     dvd   <= a_abs;
                     rem   <= '0;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (!trial[WIDTH]) begin
                  rem <= trial[WIDTH-1:0];
                  dvd <= {dvd[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shl[WIDTH-1:0];
                  dvd <= {dvd[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               bus.Quot <= div0 ? '1 : q_fix;
               bus.Rem  <= div0 ? a_raw : r_fix;
               bus.C    <= div0 ? (a_raw != '0) : (r_fix != '0);
               bus.V    <= div0 | ovf;
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_arith_div.sv
// Scoreboard bench for arith_div: directed cases plus random
// operands against a plain-arithmetic reference model.
module tb_arith_div;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   arith_div_if #(.WIDTH(W)) bus ();

   arith_div #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        c;
      logic        v;
      int          lat;
      int          t0;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(logic [31:0] q, logic [31:0] r,
                               logic c, logic v, int lat, string tag);
      exp_t e;
      e.q = q; e.r = r; e.c = c; e.v = v;
      e.lat = lat; e.t0 = 0; e.tag = tag;
      return e;
   endfunction

   // Reference: truncating division on 64-bit integers
   function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                  logic [3:0] op);
      exp_t   e;
      longint sa, sbv, ma, mb;
      sa  = op[0] ? longint'($signed(a)) : longint'({32'b0, a});
      sbv = op[0] ? longint'($signed(b)) : longint'({32'b0, b});
      ma  = sa < 0 ? -sa : sa;
      mb  = sbv < 0 ? -sbv : sbv;
      e.tag = "rand";
      e.t0  = 0;
      if (b == 32'h0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = a;
         e.v = 1'b1;
         e.lat = 1;
      end else begin
         e.q = 32'(sa / sbv);
         e.r = 32'(sa % sbv);
         e.v = op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
         e.lat = W + 1;
`ifdef ARITH_DIV_EARLY_EN
         if (ma < mb) e.lat = 1;
`endif
      end
      e.c = (e.r != 32'h0);
      return e;
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: got busy=1 want busy=0");
      end
   endtask

   task automatic issue(logic [31:0] a, logic [31:0] b,
                        logic [3:0] op, exp_t e);
      wait_idle();
      bus.A = a;
      bus.B = b;
      bus.ALUop = op;
      bus.start = 1'b1;
      e.t0 = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_done: got done=1 want no pending op");
         end else begin
            e = sb.pop_front();
            check({e.tag, "_quot"}, bus.Quot, e.q);
            check({e.tag, "_rem"}, bus.Rem, e.r);
            check({e.tag, "_c"}, 32'(bus.C), 32'(e.c));
            check({e.tag, "_v"}, 32'(bus.V), 32'(e.v));
            check({e.tag, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
         end
      end
   end

   initial begin
      logic [31:0] a, b;
      logic [3:0]  op;
      int          n;
      int          ulat;

      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.ALUop = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_quot", bus.Quot, 0);
      check("rst_rem", bus.Rem, 0);
      check("rst_cv", {30'b0, bus.C, bus.V}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(100, 7, 4'b0000, mk(14, 2, 1, 0, 33, "u100_7"));
      for (int i = 0; i < 33; i++) begin
         check("busy_hold", 32'(bus.busy), 1);
         @(negedge clk);
      end
      check("busy_drop", 32'(bus.busy), 0);

      issue(32'hFFFF_FFF9, 2, 4'b0001,
            mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, 0, 33, "sm7_2"));
      issue(7, 32'hFFFF_FFFE, 4'b0001,
            mk(32'hFFFF_FFFD, 1, 1, 0, 33, "s7_m2"));
      issue(32'h1234, 0, 4'b0000,
            mk(32'hFFFF_FFFF, 32'h1234, 1, 1, 1, "div0"));
      issue(32'h8000_0000, 32'hFFFF_FFFF, 4'b0001,
            mk(32'h8000_0000, 0, 0, 1, 33, "s_ovf"));
      ulat = 33;
`ifdef ARITH_DIV_EARLY_EN
      ulat = 1;
`endif
      issue(32'h8000_0000, 32'hFFFF_FFFF, 4'b0000,
            mk(0, 32'h8000_0000, 1, 0, ulat, "u_big"));

      issue(50, 5, 4'b0000, mk(10, 0, 0, 0, 33, "u50_5"));
      repeat (10) @(negedge clk);
      bus.A = 999;
      bus.B = 1;
      bus.ALUop = 4'b0001;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;

      issue(1000, 3, 4'b0000, mk(333, 1, 1, 0, 33, "aborted"));
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_done", 32'(bus.done), 0);
      check("abort_quot", bus.Quot, 0);
      check("abort_rem", bus.Rem, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(9, 3, 4'b0000, mk(3, 0, 0, 0, 33, "u9_3"));

      for (int k = 0; k < 150; k++) begin
         a = $urandom;
         b = $urandom;
         op = 4'($urandom);
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: a = $urandom_range(0, 100);
            4: b = -$urandom_range(1, 15);
            default: ;
         endcase
         issue(a, b, op, model(a, b, op));
      end

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
